note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
- Sequences the shared sine generator. Steps through a programmable table of up to NUM_STEPS notes. Each note is a phase increment plus a duration counted in sample ticks.
- Drives phase_inc and gate into the sine generator / audio path.
- Supports one-shot or looped playback, abort via stop, and a one-cycle done pulse on completion.

Parameters:
NUM_STEPS, 16, number of table entries
STEP_W, 4, index width, equal to log2(NUM_STEPS)
PINC_W, 24, phase increment width (440 Hz at 48 kHz = 153791)
DUR_W, 16, note duration width, in sample ticks

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sample_tick  in  1  one-cycle enable at the audio sample rate
start  in  1  begin playback; ignored while busy
stop  in  1  abort playback
loop_en  in  1  1 = wrap from last step back to step 0
last_step  in  STEP_W  index of final step; sampled when start is accepted
cfg_we  in  1  table write strobe
cfg_addr  in  STEP_W  table write index
cfg_pinc  in  PINC_W  phase increment to write; 0 = rest
cfg_dur  in  DUR_W  duration to write, in ticks
phase_inc  out  PINC_W  increment to the sine generator (registered)
gate  out  1  note active (registered)
step_idx  out  STEP_W  current step index
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at the end of non-looped playback

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=IDLE.
  - phase_inc=0, gate=0, step_idx=0, busy=0, done=0.
  - All table entries cleared to pinc=0, dur=0; latched last_step=0.
- Table:
  - Register array, written on any clk with cfg_we=1, in any state.
  - A write becomes visible at the next LOAD of that index. The note currently in PLAY is never modified.
- States:
  - IDLE: outputs phase_inc=0, gate=0.
    - start=1 and stop=0 -> LOAD, step_idx<=0, latch last_step.
  - LOAD (1 cycle, busy=1):
    - cur_pinc<=table[step_idx].pinc.
    - remaining<=table[step_idx].dur, or 1 if dur=0.
    - -> PLAY.
    - sample_tick in LOAD is ignored.
  - PLAY:
    - Registered outputs: phase_inc=cur_pinc, gate=(cur_pinc!=0); these update on the LOAD->PLAY edge.
    - On sample_tick with remaining>1: remaining--.
    - On sample_tick with remaining==1:
      - step_idx<latched last: step_idx++, -> LOAD.
      - step_idx==latched last and loop_en=1: step_idx<=0, -> LOAD.
      - step_idx==latched last and loop_en=0: -> DONE.
    - loop_en is sampled at each wrap decision, not at start.
  - DONE (1 cycle): done=1, phase_inc=0, gate=0, busy=1. -> IDLE, step_idx<=0.
- stop=1 in LOAD/PLAY/DONE:
  - Next state is IDLE; phase_inc=0, gate=0, step_idx=0, no done pulse.
  - stop has priority over start and over tick processing.
- start while busy: ignored, no restart.
- start and stop together in IDLE: stay in IDLE.
- Between notes, the LOAD cycle holds the previous phase_inc/gate. There is no glitch to 0 between consecutive notes.
- Note length:
  - Counted from entry into PLAY; the note ends on its dur-th sample_tick.
  - Total notes before done = latched last_step+1.
- reset mid-operation: identical to the power-on reset above, including table clear.
- Width rules: remaining is DUR_W bits; no arithmetic on phase_inc, passed through unmodified.

Test Plan:
1. Write step0={153791,3}, step1={307582,2}, step2={0,1}; last_step=2, loop_en=0; sample_tick every 4 clks; pulse start -> busy rises next clk. phase_inc=153791 with gate=1 for 3 ticks, then 307582 for 2 ticks, then 0 with gate=0 for 1 tick. Then a single done pulse, busy=0, step_idx=0.
2. Same table, loop_en=1 -> after step2 the sequencer returns to step0 (phase_inc=153791), never pulses done. Assert stop mid-step1 -> next clk busy=0, gate=0, phase_inc=0, no done.
3. step0={153791,0}, last_step=0 -> note lasts exactly 1 tick, then done.
4. Pulse start again during PLAY -> step_idx and remaining unaffected. start+stop together in IDLE -> busy stays 0.
5. loop_en=1, single step {153791,4}; during PLAY write step0={200000,4} -> current note keeps 153791 for all 4 ticks, next loop plays 200000.
6. Assert reset during PLAY step1 -> next clk all outputs 0. A following start with no table writes plays a 1-tick rest (gate=0), then done.

Source files
------------

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - programmable note table sequencer driving the sine generator
module note_sequencer #(
    parameter int NUM_STEPS = 16,
    parameter int STEP_W    = 4,
    parameter int PINC_W    = 24,
    parameter int DUR_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_tick,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [STEP_W-1:0] last_step,
    input  logic              cfg_we,
    input  logic [STEP_W-1:0] cfg_addr,
    input  logic [PINC_W-1:0] cfg_pinc,
    input  logic [DUR_W-1:0]  cfg_dur,
    output logic [PINC_W-1:0] phase_inc,
    output logic              gate,
    output logic [STEP_W-1:0] step_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [STEP_W-1:0]   last_q, last_d;
    logic [DUR_W-1:0]    remaining_q, remaining_d;
    logic [PINC_W-1:0]   pinc_q, pinc_d;
    logic                gate_q, gate_d;

    logic [PINC_W-1:0]   pinc_tab_q [NUM_STEPS];
    logic [DUR_W-1:0]    dur_tab_q  [NUM_STEPS];

    // Note table: writable in any state; the playing note is a private copy in pinc_q/remaining_q
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                pinc_tab_q[i] <= '0;
                dur_tab_q[i]  <= '0;
            end
        end else if (cfg_we) begin
            pinc_tab_q[cfg_addr] <= cfg_pinc;
            dur_tab_q[cfg_addr]  <= cfg_dur;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            last_q      <= '0;
            remaining_q <= '0;
            pinc_q      <= '0;
            gate_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            last_q      <= last_d;
            remaining_q <= remaining_d;
            pinc_q      <= pinc_d;
            gate_q      <= gate_d;
        end
    end

    // Next-state logic; stop overrides everything outside IDLE
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        last_d      = last_q;
        remaining_d = remaining_q;
        pinc_d      = pinc_q;
        gate_d      = gate_q;

        if (state_q != S_IDLE && stop) begin
            state_d = S_IDLE;
            step_d  = '0;
            pinc_d  = '0;
            gate_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    pinc_d = '0;
                    gate_d = 1'b0;
                    if (start && !stop) begin
                        state_d = S_LOAD;
                        step_d  = '0;
                        last_d  = last_step;
                    end
                end
                S_LOAD: begin
                    // Outputs hold the previous note until this edge, so no gap between notes
                    pinc_d      = pinc_tab_q[step_q];
                    gate_d      = (pinc_tab_q[step_q] != '0);
                    remaining_d = (dur_tab_q[step_q] == '0) ? DUR_W'(1) : dur_tab_q[step_q];
                    state_d     = S_PLAY;
                end
                S_PLAY: begin
                    if (sample_tick) begin
                        if (remaining_q > DUR_W'(1)) begin
                            remaining_d = remaining_q - DUR_W'(1);
                        end else if (step_q < last_q) begin
                            step_d  = step_q + STEP_W'(1);
                            state_d = S_LOAD;
                        end else if (loop_en) begin
                            step_d  = '0;
                            state_d = S_LOAD;
                        end else begin
                            state_d = S_DONE;
                            pinc_d  = '0;
                            gate_d  = 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    step_d  = '0;
                    pinc_d  = '0;
                    gate_d  = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign phase_inc = pinc_q;
    assign gate      = gate_q;
    assign step_idx  = step_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - directed self-checking bench for note_sequencer
module tb_note_sequencer;

    logic        clk = 1'b0;
    logic        reset, sample_tick, start, stop, loop_en, cfg_we;
    logic [3:0]  last_step, cfg_addr, step_idx;
    logic [23:0] cfg_pinc, phase_inc;
    logic [15:0] cfg_dur;
    logic        gate, busy, done;

    int checks = 0;
    int fails  = 0;
    int done_cnt = 0;

    note_sequencer dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick), .start(start), .stop(stop),
        .loop_en(loop_en), .last_step(last_step), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_pinc(cfg_pinc), .cfg_dur(cfg_dur), .phase_inc(phase_inc), .gate(gate),
        .step_idx(step_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One sample tick followed by three quiet clocks (tick every 4 clks)
    task automatic tick4();
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        cyc(); cyc(); cyc();
    endtask

    task automatic tick1();
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [23:0] p, input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_pinc = p; cfg_dur = d;
        cyc();
        cfg_we = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [23:0] p, input logic g,
                              input logic [3:0] s, input logic b);
        check({tag, ".phase_inc"}, 32'(phase_inc), 32'(p));
        check({tag, ".gate"},      32'(gate),      32'(g));
        check({tag, ".step_idx"},  32'(step_idx),  32'(s));
        check({tag, ".busy"},      32'(busy),      32'(b));
    endtask

    initial begin
        reset = 1'b1; sample_tick = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        last_step = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_pinc = '0; cfg_dur = '0;
        cyc(); cyc();
        reset = 1'b0;
        expect_out("reset", 24'd0, 1'b0, 4'd0, 1'b0);
        check("reset.done", 32'(done), 32'd0);

        // 1: one-shot three-note sequence
        wr(4'd0, 24'd153791, 16'd3);
        wr(4'd1, 24'd307582, 16'd2);
        wr(4'd2, 24'd0,      16'd1);
        last_step = 4'd2; loop_en = 1'b0;
        go();
        expect_out("t1.load", 24'd0, 1'b0, 4'd0, 1'b1);
        cyc();
        expect_out("t1.n0", 24'd153791, 1'b1, 4'd0, 1'b1);
        last_step = 4'd0;
        tick4(); tick4();
        expect_out("t1.n0t2", 24'd153791, 1'b1, 4'd0, 1'b1);
        tick4();
        expect_out("t1.n1", 24'd307582, 1'b1, 4'd1, 1'b1);
        tick4(); tick4();
        expect_out("t1.n2", 24'd0, 1'b0, 4'd2, 1'b1);
        tick1();
        check("t1.done", 32'(done), 32'd1);
        expect_out("t1.donest", 24'd0, 1'b0, 4'd2, 1'b1);
        cyc();
        check("t1.done_end", 32'(done), 32'd0);
        expect_out("t1.idle", 24'd0, 1'b0, 4'd0, 1'b0);
        check("t1.done_cnt", 32'(done_cnt), 32'd1);

        // 2: looped playback, stop mid step1
        loop_en = 1'b1; last_step = 4'd2;
        go(); cyc();
        tick4(); tick4(); tick4();
        tick4(); tick4();
        expect_out("t2.n2", 24'd0, 1'b0, 4'd2, 1'b1);
        tick4();
        expect_out("t2.wrap", 24'd153791, 1'b1, 4'd0, 1'b1);
        tick4(); tick4(); tick4();
        tick4();
        expect_out("t2.mid1", 24'd307582, 1'b1, 4'd1, 1'b1);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        expect_out("t2.stop", 24'd0, 1'b0, 4'd0, 1'b0);
        check("t2.done", 32'(done), 32'd0);
        check("t2.done_cnt", 32'(done_cnt), 32'd1);

        // 3: zero duration plays one tick
        wr(4'd0, 24'd153791, 16'd0);
        last_step = 4'd0; loop_en = 1'b0;
        go(); cyc();
        expect_out("t3.n0", 24'd153791, 1'b1, 4'd0, 1'b1);
        tick1();
        check("t3.done", 32'(done), 32'd1);
        cyc();
        check("t3.idle.busy", 32'(busy), 32'd0);
        check("t3.done_cnt", 32'(done_cnt), 32'd2);

        // 4: start ignored while busy; start+stop in IDLE
        wr(4'd0, 24'd153791, 16'd3);
        go(); cyc();
        tick4();
        go();
        expect_out("t4.restart", 24'd153791, 1'b1, 4'd0, 1'b1);
        tick4();
        expect_out("t4.t2", 24'd153791, 1'b1, 4'd0, 1'b1);
        tick1();
        check("t4.done", 32'(done), 32'd1);
        cyc();
        check("t4.done_cnt", 32'(done_cnt), 32'd3);
        start = 1'b1; stop = 1'b1;
        cyc();
        check("t4.ss.busy", 32'(busy), 32'd0);
        start = 1'b0; stop = 1'b0;
        cyc();
        check("t4.ss.busy2", 32'(busy), 32'd0);

        // 5: table write during PLAY affects only the next pass
        wr(4'd0, 24'd153791, 16'd4);
        loop_en = 1'b1;
        go(); cyc();
        wr(4'd0, 24'd200000, 16'd4);
        tick4(); tick4(); tick4();
        expect_out("t5.keep", 24'd153791, 1'b1, 4'd0, 1'b1);
        tick4();
        expect_out("t5.new", 24'd200000, 1'b1, 4'd0, 1'b1);
        stop = 1'b1; cyc(); stop = 1'b0;
        check("t5.stop.busy", 32'(busy), 32'd0);

        // 6: reset during PLAY clears everything including the table
        wr(4'd0, 24'd153791, 16'd1);
        wr(4'd1, 24'd307582, 16'd2);
        last_step = 4'd1; loop_en = 1'b0;
        go(); cyc();
        tick4();
        expect_out("t6.n1", 24'd307582, 1'b1, 4'd1, 1'b1);
        reset = 1'b1; cyc(); reset = 1'b0;
        expect_out("t6.reset", 24'd0, 1'b0, 4'd0, 1'b0);
        check("t6.reset.done", 32'(done), 32'd0);
        last_step = 4'd0;
        go(); cyc();
        expect_out("t6.rest", 24'd0, 1'b0, 4'd0, 1'b1);
        tick1();
        check("t6.done", 32'(done), 32'd1);
        cyc();
        check("t6.idle.busy", 32'(busy), 32'd0);
        check("t6.done_cnt", 32'(done_cnt), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
